axi_ram_responder: RTL and testbench

- AXI4 slave that answers the SoC's external-memory AXI master (`ext_mem`) with a byte-addressable on-chip RAM.
- It stands in for DDR in simulation and in FPGA builds without DDR, and is wired directly to the SoC `axi_*` ports.
- One transaction is serviced at a time: either a read burst or a write burst.
- Supports INCR and FIXED bursts, narrow transfers and backpressure on R and B.

---
 rtl/axi_ram_responder_pkg.sv | 41 ++++
 rtl/axi_ram_sp_be.sv | 39 +++
 rtl/axi_ram_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_responder_pkg.sv
// Shared definitions for the AXI RAM responder.
// Holds the AXI burst and response encodings, the controller state encoding,
// and helpers for the per-beat address update and request legality.
package axi_ram_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_RESP = 2'd3
    } state_t;

    // Address of the next beat. FIXED holds the address; everything else
    // advances by the transfer size. Unsupported burst types never reach
    // the RAM with meaningful data, so they simply advance like INCR.
    function automatic logic [31:0] addr_next(input logic [1:0]  burst,
                                              input logic [2:0]  size,
                                              input logic [31:0] addr);
        logic [31:0] step;
        step = 32'd1 << size;
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return addr + step;
    endfunction

    // WRAP, the reserved burst code and transfers wider than 32 bits are
    // answered with SLVERR.
    function automatic logic req_err(input logic [1:0] burst,
                                     input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd2);
    endfunction

endpackage

// File: rtl/axi_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Ports:
//   clk   - clock
//   re    - read enable; rdata updates one cycle later, otherwise it holds
//   we    - byte write enables (one bit per byte lane)
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
// HEXFILE is accepted for interface compatibility; contents start unset.
module axi_ram_sp_be #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter     HEXFILE = "none"
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // No reset: RAM contents and the read register survive srst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (we[i]) begin
                mem_reg[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem_reg[addr];
        end
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by an on-chip byte-addressable RAM, standing in for
// external memory. Services one read or write burst at a time, supports
// INCR and FIXED bursts, narrow transfers and R/B backpressure.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   axi_aw* / axi_w* / axi_b* - write address, write data, write response
//   axi_ar* / axi_r*        - read address, read data
// Lock/cache/prot/qos inputs are accepted and ignored.
module axi_ram_responder
    import axi_ram_responder_pkg::*;
#(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 14,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter     HEXFILE    = "none"
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic [1:0]              axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [2:0]              axi_awprot_i,
    input  logic [3:0]              axi_awqos_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic [1:0]              axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [2:0]              axi_arprot_i,
    input  logic [3:0]              axi_arqos_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int RAM_AW = AXI_ADDR_W - 2;

    state_t                  state_reg;
    logic                    arb_rd_reg;   // contested grant goes to read when set
    logic [AXI_ID_W-1:0]     id_reg;
    logic [AXI_ADDR_W-1:0]   addr_reg;
    logic [AXI_LEN_W-1:0]    len_reg;
    logic [2:0]              size_reg;
    logic [1:0]              burst_reg;
    logic                    err_reg;
    logic [AXI_LEN_W:0]      cnt_reg;      // beats issued (RD) / accepted (WR)
    logic                    wready_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    logic                    rvalid_reg;
    logic                    rlast_reg;
    logic [1:0]              rresp_reg;

    logic                    idle;
    logic                    both_valid;
    logic                    ar_go;
    logic                    aw_go;
    logic                    rd_issue;
    logic                    w_go;
    logic                    w_beyond;
    logic                    w_err_next;
    logic [AXI_DATA_W/8-1:0] ram_we;
    logic [AXI_DATA_W-1:0]   ram_rdata;
    logic [31:0]             addr_inc;
    logic [AXI_ADDR_W-1:0]   addr_adv;
    logic [AXI_LEN_W:0]      len_ext;
    logic [AXI_LEN_W:0]      cnt_inc;
    logic                    unused_bits;

    assign idle       = (state_reg == ST_IDLE) && !rst_i;
    assign both_valid = axi_arvalid_i && axi_awvalid_i;

    // Under contention only the granted channel sees ready.
    assign axi_arready_o = idle && !(both_valid && !arb_rd_reg);
    assign axi_awready_o = idle && !(both_valid && arb_rd_reg);
    assign ar_go = axi_arready_o && axi_arvalid_i;
    assign aw_go = axi_awready_o && axi_awvalid_i;

    assign len_ext = {1'b0, len_reg};
    assign cnt_inc = cnt_reg + {{AXI_LEN_W{1'b0}}, 1'b1};

    // A read is issued whenever beats remain and the output slot is free
    // or being drained this cycle, giving one beat per cycle.
    assign rd_issue = (state_reg == ST_RD) && (cnt_reg <= len_ext) &&
                      (!rvalid_reg || axi_rready_i);

    assign w_go       = wready_reg && axi_wvalid_i;
    assign w_beyond   = cnt_reg > len_ext;
    assign w_err_next = err_reg || w_beyond ||
                        (axi_wlast_i && (cnt_reg != len_ext));
    // An early wlast is still written; only prior errors or overrun block it.
    assign ram_we     = (w_go && !err_reg && !w_beyond) ? axi_wstrb_i : '0;

    assign addr_inc = addr_next(burst_reg, size_reg,
                                {{(32-AXI_ADDR_W){1'b0}}, addr_reg});
    assign addr_adv = addr_inc[AXI_ADDR_W-1:0];

    assign unused_bits = ^{axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i,
                           axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i,
                           addr_inc[31:AXI_ADDR_W]};

    axi_ram_sp_be #(
        .ADDR_W  (RAM_AW),
        .DATA_W  (AXI_DATA_W),
        .HEXFILE (HEXFILE)
    ) u_ram (
        .clk   (clk_i),
        .re    (rd_issue),
        .we    (ram_we),
        .addr  (addr_reg[AXI_ADDR_W-1:2]),
        .wdata (axi_wdata_i),
        .rdata (ram_rdata)
    );

    assign axi_wready_o = wready_reg;
    assign axi_bvalid_o = bvalid_reg;
    assign axi_bresp_o  = bresp_reg;
    assign axi_bid_o    = id_reg;
    assign axi_rvalid_o = rvalid_reg;
    assign axi_rlast_o  = rlast_reg;
    assign axi_rresp_o  = rresp_reg;
    assign axi_rid_o    = id_reg;
    // err_reg is constant for the whole burst, so rdata stays stable on stalls.
    assign axi_rdata_o  = err_reg ? '0 : ram_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            arb_rd_reg <= 1'b1;
            id_reg     <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            size_reg   <= '0;
            burst_reg  <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
            wready_reg <= 1'b0;
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (ar_go) begin
                        id_reg    <= axi_arid_i;
                        addr_reg  <= axi_araddr_i;
                        len_reg   <= axi_arlen_i;
                        size_reg  <= axi_arsize_i;
                        burst_reg <= axi_arburst_i;
                        err_reg   <= req_err(axi_arburst_i, axi_arsize_i);
                        state_reg <= ST_RD;
                    end else if (aw_go) begin
                        id_reg     <= axi_awid_i;
                        addr_reg   <= axi_awaddr_i;
                        len_reg    <= axi_awlen_i;
                        size_reg   <= axi_awsize_i;
                        burst_reg  <= axi_awburst_i;
                        err_reg    <= req_err(axi_awburst_i, axi_awsize_i);
                        wready_reg <= 1'b1;
                        state_reg  <= ST_WR;
                    end
                    // The pointer only moves when both channels competed, so
                    // an uncontested grant does not disturb the rotation.
                    if (both_valid) begin
                        arb_rd_reg <= !arb_rd_reg;
                    end
                end
                ST_RD: begin
                    if (rd_issue) begin
                        rvalid_reg <= 1'b1;
                        rlast_reg  <= (cnt_reg == len_ext);
                        rresp_reg  <= err_reg ? RESP_SLVERR : RESP_OKAY;
                        cnt_reg    <= cnt_inc;
                        addr_reg   <= addr_adv;
                    end else if (axi_rready_i) begin
                        rvalid_reg <= 1'b0;
                        rlast_reg  <= 1'b0;
                    end
                    if (rvalid_reg && axi_rready_i && rlast_reg) begin
                        rresp_reg <= RESP_OKAY;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (w_go) begin
                        if (!w_beyond) begin
                            cnt_reg <= cnt_inc;
                        end
                        addr_reg <= addr_adv;
                        err_reg  <= w_err_next;
                        if (axi_wlast_i) begin
                            wready_reg <= 1'b0;
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                            state_reg  <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bready_i) begin
                        bvalid_reg <= 1'b0;
                        bresp_reg  <= RESP_OKAY;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
module tb_axi_ram_responder;
    import axi_ram_responder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  axi_awid_i, axi_arid_i;
    logic [13:0] axi_awaddr_i, axi_araddr_i;
    logic [7:0]  axi_awlen_i, axi_arlen_i;
    logic [2:0]  axi_awsize_i, axi_arsize_i;
    logic [1:0]  axi_awburst_i, axi_arburst_i;
    logic        axi_awvalid_i, axi_awready_o, axi_arvalid_i, axi_arready_o;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_wstrb_i;
    logic        axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic [3:0]  axi_bid_o, axi_rid_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic        axi_bvalid_o, axi_bready_i;
    logic [31:0] axi_rdata_o;
    logic        axi_rlast_o, axi_rvalid_o, axi_rready_i;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_cyc  [16];
    int          rd_n;

    always #5 clk_i = ~clk_i;

    axi_ram_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i),
        .axi_awlock_i(2'b00), .axi_awcache_i(4'h0), .axi_awprot_i(3'b000), .axi_awqos_i(4'h0),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i),
        .axi_arlock_i(2'b00), .axi_arcache_i(4'h0), .axi_arprot_i(3'b000), .axi_arqos_i(4'h0),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: handshake never happened within the cycle budget", name);
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [13:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len;
        axi_awsize_i = size; axi_awburst_i = burst;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [13:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len;
        axi_arsize_i = size; axi_arburst_i = burst;
    endtask

    // All tasks start and end just after a falling edge.
    task automatic aw_hs();
        axi_awvalid_i = 1'b1;
        for (int n = 0; ; n++) begin
            #1;
            if (axi_awready_o) break;
            if (n >= 100) begin
                timeout("aw_handshake");
                axi_awvalid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        axi_awvalid_i = 1'b0;
    endtask

    task automatic ar_hs();
        axi_arvalid_i = 1'b1;
        for (int n = 0; ; n++) begin
            #1;
            if (axi_arready_o) break;
            if (n >= 100) begin
                timeout("ar_handshake");
                axi_arvalid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        axi_arvalid_i = 1'b0;
    endtask

    // Sends beats 0..last_at (data0+beat), then collects the B response.
    task automatic w_send_b(input logic [31:0] data0, input logic [3:0] strb, input int last_at,
                            output logic [1:0] resp, output logic [3:0] bid);
        resp = 2'bxx;
        bid  = 4'hx;
        for (int b = 0; b <= last_at; b++) begin
            axi_wdata_i  = data0 + 32'(b);
            axi_wstrb_i  = strb;
            axi_wlast_i  = (b == last_at);
            axi_wvalid_i = 1'b1;
            for (int n = 0; ; n++) begin
                #1;
                if (axi_wready_o) break;
                if (n >= 100) begin
                    timeout("w_handshake");
                    axi_wvalid_i = 1'b0;
                    return;
                end
                @(negedge clk_i);
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        axi_wvalid_i = 1'b0;
        axi_wlast_i  = 1'b0;
        axi_bready_i = 1'b1;
        for (int n = 0; ; n++) begin
            #1;
            if (axi_bvalid_o) break;
            if (n >= 100) begin
                timeout("b_handshake");
                axi_bready_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        resp = axi_bresp_o;
        bid  = axi_bid_o;
        @(posedge clk_i);
        @(negedge clk_i);
        axi_bready_i = 1'b0;
    endtask

    // Collects R beats; cycle 1 is the falling edge right after the AR
    // handshake. toggle=1 drives rready 0/1 alternately. abort_after>0 stops
    // after that many beats.
    task automatic r_collect(input bit toggle, input int abort_after);
        int cyc;
        bit done;
        bit stalled;
        logic [31:0] hold_d;
        logic        hold_l;
        cyc = 1; done = 0; stalled = 0; rd_n = 0; hold_d = '0; hold_l = 1'b0;
        while (!done && cyc < 200) begin
            axi_rready_i = toggle ? cyc[0] : 1'b1;
            #1;
            if (stalled) begin
                check("stall_rvalid", 32'(axi_rvalid_o), 32'd1);
                check("stall_rdata", axi_rdata_o, hold_d);
                check("stall_rlast", 32'(axi_rlast_o), 32'(hold_l));
            end
            stalled = axi_rvalid_o && !axi_rready_i;
            hold_d  = axi_rdata_o;
            hold_l  = axi_rlast_o;
            if (axi_rvalid_o && axi_rready_i && rd_n < 16) begin
                rd_data[rd_n] = axi_rdata_o;
                rd_resp[rd_n] = axi_rresp_o;
                rd_last[rd_n] = axi_rlast_o;
                rd_id[rd_n]   = axi_rid_o;
                rd_cyc[rd_n]  = cyc;
                rd_n++;
                if (axi_rlast_o || rd_n == abort_after) done = 1;
            end
            @(negedge clk_i);
            cyc++;
        end
        axi_rready_i = 1'b0;
        if (!done) timeout("r_collect");
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [13:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [1:0] bresp;
        logic [3:0] bid;

        vecs[0]  = '{1'b1, 4'h1, 14'h010, 3'd2, BURST_INCR,  32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 4'h2, 14'h010, 3'd2, BURST_INCR,  32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'h3, 14'h200, 3'd2, BURST_INCR,  32'h11223344, 4'hF, RESP_OKAY,   32'h0};
        vecs[3]  = '{1'b1, 4'h4, 14'h201, 3'd0, BURST_INCR,  32'h0000AB00, 4'h2, RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b0, 4'h5, 14'h200, 3'd2, BURST_INCR,  32'h0,        4'h0, RESP_OKAY,   32'h1122AB44};
        vecs[5]  = '{1'b1, 4'h6, 14'h010, 3'd2, BURST_WRAP,  32'hCAFEF00D, 4'hF, RESP_SLVERR, 32'h0};
        vecs[6]  = '{1'b0, 4'h7, 14'h010, 3'd2, BURST_INCR,  32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF};
        vecs[7]  = '{1'b0, 4'h8, 14'h010, 3'd3, BURST_INCR,  32'h0,        4'h0, RESP_SLVERR, 32'h0};
        vecs[8]  = '{1'b1, 4'h9, 14'h024, 3'd2, BURST_FIXED, 32'h0A0B0C0D, 4'hF, RESP_OKAY,   32'h0};
        vecs[9]  = '{1'b0, 4'hA, 14'h024, 3'd2, BURST_FIXED, 32'h0,        4'h0, RESP_OKAY,   32'h0A0B0C0D};
        vecs[10] = '{1'b1, 4'hB, 14'h200, 3'd2, BURST_INCR,  32'h55660000, 4'hC, RESP_OKAY,   32'h0};
        vecs[11] = '{1'b0, 4'hC, 14'h200, 3'd1, BURST_INCR,  32'h0,        4'h0, RESP_OKAY,   32'h5566AB44};
        vecs[12] = '{1'b1, 4'hD, 14'h028, 3'd2, 2'b11,       32'h12345678, 4'hF, RESP_SLVERR, 32'h0};
        vecs[13] = '{1'b0, 4'hE, 14'h024, 3'd2, 2'b11,       32'h0,        4'h0, RESP_SLVERR, 32'h0};

        rst_i = 1'b1;
        axi_awvalid_i = 0; axi_arvalid_i = 0; axi_wvalid_i = 0; axi_wlast_i = 0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_bready_i = 0; axi_rready_i = 0;
        set_aw(4'h0, 14'h0, 8'h0, 3'd0, BURST_INCR);
        set_ar(4'h0, 14'h0, 8'h0, 3'd0, BURST_INCR);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_arready", 32'(axi_arready_o), 32'd0);
        check("rst_awready", 32'(axi_awready_o), 32'd0);
        check("rst_wready",  32'(axi_wready_o),  32'd0);
        check("rst_bvalid",  32'(axi_bvalid_o),  32'd0);
        check("rst_rvalid",  32'(axi_rvalid_o),  32'd0);
        check("rst_rlast",   32'(axi_rlast_o),   32'd0);
        check("rst_resps",   32'({axi_bresp_o, axi_rresp_o}), 32'd0);
        check("rst_ids",     32'({axi_bid_o, axi_rid_o}),     32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("idle_arready", 32'(axi_arready_o), 32'd1);
        check("idle_awready", 32'(axi_awready_o), 32'd1);
        @(negedge clk_i);

        // Single-beat table.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                set_aw(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst);
                aw_hs();
                w_send_b(vecs[i].wdata, vecs[i].strb, 0, bresp, bid);
                $display("vec %0d write addr=%h data=%h strb=%h bresp=%0d bid=%0d",
                         i, vecs[i].addr, vecs[i].wdata, vecs[i].strb, bresp, bid);
                check($sformatf("vec%0d_bresp", i), 32'(bresp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_bid", i), 32'(bid), 32'(vecs[i].id));
            end else begin
                set_ar(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst);
                ar_hs();
                r_collect(1'b0, 0);
                $display("vec %0d read addr=%h rdata=%h rresp=%0d rid=%0d beats=%0d",
                         i, vecs[i].addr, rd_data[0], rd_resp[0], rd_id[0], rd_n);
                check($sformatf("vec%0d_beats", i), 32'(rd_n), 32'd1);
                check($sformatf("vec%0d_rdata", i), rd_data[0], vecs[i].rdata);
                check($sformatf("vec%0d_rresp", i), 32'(rd_resp[0]), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rid", i), 32'(rd_id[0]), 32'(vecs[i].id));
                check($sformatf("vec%0d_rlast", i), 32'(rd_last[0]), 32'd1);
                check($sformatf("vec%0d_latency", i), 32'(rd_cyc[0]), 32'd2);
            end
        end

        // 8-beat INCR write then read with rready held high.
        set_aw(4'h5, 14'h100, 8'd7, 3'd2, BURST_INCR);
        aw_hs();
        w_send_b(32'hA0000000, 4'hF, 7, bresp, bid);
        $display("burst write addr=100 len=7 bresp=%0d", bresp);
        check("burst_w_bresp", 32'(bresp), 32'(RESP_OKAY));
        set_ar(4'h6, 14'h100, 8'd7, 3'd2, BURST_INCR);
        ar_hs();
        r_collect(1'b0, 0);
        $display("burst read rready=1 beats=%0d first=%0d", rd_n, rd_cyc[0]);
        check("burst_r_beats", 32'(rd_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("burst_r_data%0d", i), rd_data[i], 32'hA0000000 + 32'(i));
            check($sformatf("burst_r_last%0d", i), 32'(rd_last[i]), 32'(i == 7));
            check($sformatf("burst_r_cyc%0d", i), 32'(rd_cyc[i]), 32'(2 + i));
        end

        // Same burst with rready toggling.
        set_ar(4'h7, 14'h100, 8'd7, 3'd2, BURST_INCR);
        ar_hs();
        r_collect(1'b1, 0);
        $display("burst read rready toggling beats=%0d", rd_n);
        check("toggle_r_beats", 32'(rd_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("toggle_r_data%0d", i), rd_data[i], 32'hA0000000 + 32'(i));
            check($sformatf("toggle_r_last%0d", i), 32'(rd_last[i]), 32'(i == 7));
        end

        // Early wlast at beat 2 of a len-3 burst.
        set_aw(4'h8, 14'h400, 8'd3, 3'd2, BURST_INCR);
        aw_hs();
        w_send_b(32'h40000000, 4'hF, 2, bresp, bid);
        $display("early wlast write bresp=%0d", bresp);
        check("early_wlast_bresp", 32'(bresp), 32'(RESP_SLVERR));

        // Beat past len: first beat lands, second does not.
        set_aw(4'h9, 14'h300, 8'd0, 3'd2, BURST_INCR);
        aw_hs();
        w_send_b(32'h77770000, 4'hF, 1, bresp, bid);
        $display("overrun write bresp=%0d", bresp);
        check("overrun_bresp", 32'(bresp), 32'(RESP_SLVERR));
        set_ar(4'h9, 14'h300, 8'd0, 3'd2, BURST_INCR);
        ar_hs();
        r_collect(1'b0, 0);
        $display("overrun readback rdata=%h", rd_data[0]);
        check("overrun_readback", rd_data[0], 32'h77770000);

        // Contention, first round: read wins after reset.
        set_ar(4'h3, 14'h010, 8'd0, 3'd2, BURST_INCR);
        set_aw(4'hC, 14'h500, 8'd0, 3'd2, BURST_INCR);
        axi_arvalid_i = 1'b1;
        axi_awvalid_i = 1'b1;
        #1;
        check("arb1_arready", 32'(axi_arready_o), 32'd1);
        check("arb1_awready", 32'(axi_awready_o), 32'd0);
        ar_hs();
        r_collect(1'b0, 0);
        $display("arb1 read rid=%0d rdata=%h", rd_id[0], rd_data[0]);
        check("arb1_rid", 32'(rd_id[0]), 32'h3);
        check("arb1_rdata", rd_data[0], 32'hDEADBEEF);
        aw_hs();
        w_send_b(32'h5A5A0001, 4'hF, 0, bresp, bid);
        $display("arb1 write bid=%0d bresp=%0d", bid, bresp);
        check("arb1_bid", 32'(bid), 32'hC);

        // Contention, second round: write wins.
        set_ar(4'h2, 14'h500, 8'd0, 3'd2, BURST_INCR);
        set_aw(4'hB, 14'h504, 8'd0, 3'd2, BURST_INCR);
        axi_arvalid_i = 1'b1;
        axi_awvalid_i = 1'b1;
        #1;
        check("arb2_awready", 32'(axi_awready_o), 32'd1);
        check("arb2_arready", 32'(axi_arready_o), 32'd0);
        aw_hs();
        w_send_b(32'h5A5A0002, 4'hF, 0, bresp, bid);
        $display("arb2 write bid=%0d bresp=%0d", bid, bresp);
        check("arb2_bid", 32'(bid), 32'hB);
        ar_hs();
        r_collect(1'b0, 0);
        $display("arb2 read rid=%0d rdata=%h", rd_id[0], rd_data[0]);
        check("arb2_rid", 32'(rd_id[0]), 32'h2);
        check("arb2_rdata", rd_data[0], 32'h5A5A0001);

        // Reset in the middle of an 8-beat read.
        set_ar(4'h4, 14'h100, 8'd7, 3'd2, BURST_INCR);
        ar_hs();
        r_collect(1'b0, 3);
        check("abort_beats", 32'(rd_n), 32'd3);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("abort_rvalid", 32'(axi_rvalid_o), 32'd0);
        check("abort_arready_in_rst", 32'(axi_arready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("abort_idle_arready", 32'(axi_arready_o), 32'd1);
        check("abort_idle_awready", 32'(axi_awready_o), 32'd1);
        @(negedge clk_i);
        set_ar(4'h1, 14'h104, 8'd0, 3'd2, BURST_INCR);
        ar_hs();
        r_collect(1'b0, 0);
        $display("post-reset read rdata=%h rresp=%0d", rd_data[0], rd_resp[0]);
        check("post_reset_rdata", rd_data[0], 32'hA0000001);
        check("post_reset_rresp", 32'(rd_resp[0]), 32'(RESP_OKAY));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
